// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - stall/flush sequencer for the 5-stage pipeline
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bubble,
    input  logic             redirect_x,
    input  logic             imem_ack,
    input  logic             dmem_req_m,
    input  logic             dmem_ack,
    input  logic             halt,
    input  logic             resume,
    output logic             en_pc,
    output logic             en_fd,
    output logic             en_dx,
    output logic             en_xm,
    output logic             en_mw,
    output logic             flush_fd,
    output logic             flush_dx,
    output logic             mem_err,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles
);

    // Wide enough to hold MEM_TIMEOUT itself.
    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

    // Enable vectors, bit order {pc, fd, dx, xm, mw}.
    localparam logic [4:0] EN_ALL    = 5'b11111;
    localparam logic [4:0] EN_NONE   = 5'b00000;
    localparam logic [4:0] EN_BUBBLE = 5'b00111;
    localparam logic [4:0] EN_IWAIT  = 5'b01111;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2,
        ERROR    = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [TO_W-1:0] wait_cnt;
    logic [TO_W-1:0] wait_cnt_next;
    logic            mem_err_next;

    logic [4:0]      flow_en;
    logic            flow_flush_fd;
    logic            flow_flush_dx;
    logic            flow_quiet;

    logic [4:0]      fsm_en;
    logic            fsm_flush_fd;
    logic            fsm_flush_dx;

    logic            mem_stall;
    logic            wait_expired;

    assign mem_stall    = dmem_req_m && !dmem_ack;
    assign wait_expired = (wait_cnt == TO_W'(MEM_TIMEOUT));
    assign state_o      = state;

    // Normal-flow pattern: redirect beats load-use bubble, which beats fetch wait.
    always_comb begin
        flow_en       = EN_ALL;
        flow_flush_fd = 1'b0;
        flow_flush_dx = 1'b0;
        flow_quiet    = 1'b0;
        if (redirect_x) begin
            flow_flush_fd = 1'b1;
            flow_flush_dx = 1'b1;
        end else if (bubble) begin
            flow_en       = EN_BUBBLE;
            flow_flush_dx = 1'b1;
        end else if (!imem_ack) begin
            flow_en       = EN_IWAIT;
            flow_flush_fd = 1'b1;
        end else begin
            flow_quiet    = 1'b1;
        end
    end

    // Next-state, watchdog and enable selection per controller state.
    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        mem_err_next  = mem_err;
        fsm_en        = EN_NONE;
        fsm_flush_fd  = 1'b0;
        fsm_flush_dx  = 1'b0;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = TO_W'(1);
                end else if (flow_quiet && halt) begin
                    // Halt only when nothing else needs the pipeline to move.
                    state_next = HALTED;
                end else begin
                    fsm_en       = flow_en;
                    fsm_flush_fd = flow_flush_fd;
                    fsm_flush_dx = flow_flush_dx;
                end
            end
            MEM_WAIT: begin
                if (dmem_ack) begin
                    // Completion cycle behaves like RUN; halt waits until then.
                    fsm_en        = flow_en;
                    fsm_flush_fd  = flow_flush_fd;
                    fsm_flush_dx  = flow_flush_dx;
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (wait_expired) begin
                    state_next   = ERROR;
                    mem_err_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + TO_W'(1);
                end
            end
            HALTED: begin
                if (resume) begin
                    state_next = RUN;
                end
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Drive the pipeline controls; reset forces everything stalled and flushed.
    always_comb begin
        {en_pc, en_fd, en_dx, en_xm, en_mw} = fsm_en;
        flush_fd = fsm_flush_fd;
        flush_dx = fsm_flush_dx;
        if (reset) begin
            {en_pc, en_fd, en_dx, en_xm, en_mw} = EN_NONE;
            flush_fd = 1'b1;
            flush_dx = 1'b1;
        end
    end

    // Controller state, watchdog count and sticky memory error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            mem_err  <= mem_err_next;
        end
    end

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (!en_pc && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - self-checking bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;
    localparam int SMALL_W     = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, bubble, redirect_x, imem_ack, dmem_req_m, dmem_ack, halt, resume;

    logic en_pc, en_fd, en_dx, en_xm, en_mw, flush_fd, flush_dx, mem_err;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cycles;

    logic s_en_pc, s_en_fd, s_en_dx, s_en_xm, s_en_mw, s_flush_fd, s_flush_dx, s_mem_err;
    logic [1:0]         s_state_o;
    logic [SMALL_W-1:0] s_stall_cycles;

    logic [6:0] outs;
    logic [6:0] s_outs;
    assign outs   = {en_pc, en_fd, en_dx, en_xm, en_mw, flush_fd, flush_dx};
    assign s_outs = {s_en_pc, s_en_fd, s_en_dx, s_en_xm, s_en_mw, s_flush_fd, s_flush_dx};

    pipeline_stall_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .bubble(bubble), .redirect_x(redirect_x),
        .imem_ack(imem_ack), .dmem_req_m(dmem_req_m), .dmem_ack(dmem_ack),
        .halt(halt), .resume(resume),
        .en_pc(en_pc), .en_fd(en_fd), .en_dx(en_dx), .en_xm(en_xm), .en_mw(en_mw),
        .flush_fd(flush_fd), .flush_dx(flush_dx), .mem_err(mem_err),
        .state_o(state_o), .stall_cycles(stall_cycles)
    );

    pipeline_stall_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(SMALL_W)) dut_small (
        .clk(clk), .reset(reset), .bubble(bubble), .redirect_x(redirect_x),
        .imem_ack(imem_ack), .dmem_req_m(dmem_req_m), .dmem_ack(dmem_ack),
        .halt(halt), .resume(resume),
        .en_pc(s_en_pc), .en_fd(s_en_fd), .en_dx(s_en_dx), .en_xm(s_en_xm), .en_mw(s_en_mw),
        .flush_fd(s_flush_fd), .flush_dx(s_flush_dx), .mem_err(s_mem_err),
        .state_o(s_state_o), .stall_cycles(s_stall_cycles)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 run, 1 memory wait, 2 halted, 3 error.
    int     m_mode = 0;
    int     m_pend = 0;
    logic   m_err  = 1'b0;
    longint m_stall = 0;

    function automatic logic [6:0] flow_outs();
        if (redirect_x) return 7'b1111111;
        if (bubble)     return 7'b0011101;
        if (!imem_ack)  return 7'b0111110;
        return 7'b1111100;
    endfunction

    function automatic logic [6:0] model_outs();
        if (reset) return 7'b0000011;
        case (m_mode)
            0: begin
                if (dmem_req_m && !dmem_ack) return 7'b0000000;
                if (halt && !redirect_x && !bubble && imem_ack) return 7'b0000000;
                return flow_outs();
            end
            1: return dmem_ack ? flow_outs() : 7'b0000000;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic void model_step(input logic pc_moved);
        if (reset) begin
            m_mode = 0; m_pend = 0; m_err = 1'b0; m_stall = 0;
            return;
        end
        if (!pc_moved) m_stall++;
        case (m_mode)
            0: begin
                if (dmem_req_m && !dmem_ack) begin
                    m_mode = 1; m_pend = 1;
                end else if (halt && !redirect_x && !bubble && imem_ack) begin
                    m_mode = 2;
                end
            end
            1: begin
                if (dmem_ack) begin
                    m_mode = 0; m_pend = 0;
                end else begin
                    m_pend++;
                    if (m_pend > MEM_TIMEOUT) begin
                        m_mode = 3; m_err = 1'b1;
                    end
                end
            end
            2: if (resume) m_mode = 0;
            default: ;
        endcase
    endfunction

    function automatic logic [SMALL_W-1:0] small_stall();
        return (m_stall > 15) ? 4'hF : SMALL_W'(m_stall);
    endfunction

    task automatic drive(input logic r, input logic b, input logic rx, input logic ia,
                         input logic dr, input logic da, input logic h, input logic rs);
        @(negedge clk);
        reset = r; bubble = b; redirect_x = rx; imem_ack = ia;
        dmem_req_m = dr; dmem_ack = da; halt = h; resume = rs;
        #1;
    endtask

    task automatic tick();
        logic [6:0] e;
        e = model_outs();
        @(posedge clk);
        model_step(e[6]);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 1, 0, 0, 0, 0);
            checks++;
            if (outs !== 7'b0000011) begin
                errors++;
                $display("FAIL reset_outs cycle %0d: got %b want %b", i, outs, 7'b0000011);
            end
            tick();
        end
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (state_o !== 2'd0 || outs !== 7'b1111100 || stall_cycles !== '0 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: state %0d outs %b stall %0d err %b want 0 1111100 0 0",
                     state_o, outs, stall_cycles, mem_err);
        end
        tick();
    endtask

    task automatic test_bubble();
        longint s0;
        s0 = m_stall;
        drive(0, 1, 0, 1, 0, 0, 0, 0);
        checks++;
        if (outs !== 7'b0011101) begin
            errors++;
            $display("FAIL bubble_outs: got %b want %b", outs, 7'b0011101);
        end
        tick();
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (outs !== 7'b1111100 || stall_cycles !== CNT_W'(s0 + 1)) begin
            errors++;
            $display("FAIL bubble_after: outs %b stall %0d want 1111100 %0d", outs, stall_cycles, s0 + 1);
        end
        tick();
    endtask

    task automatic test_bubble_redirect();
        longint s0;
        s0 = m_stall;
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        checks++;
        if (outs !== 7'b1111111) begin
            errors++;
            $display("FAIL redirect_outs: got %b want %b", outs, 7'b1111111);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (outs !== 7'b0111110 || stall_cycles !== CNT_W'(s0)) begin
            errors++;
            $display("FAIL redirect_after: outs %b stall %0d want 0111110 %0d", outs, stall_cycles, s0);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        longint s0;
        int     waits;
        s0 = m_stall;
        waits = 0;
        drive(0, 0, 0, 1, 1, 0, 0, 0);
        checks++;
        if (outs !== 7'b0000000 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL memwait_start: outs %b state %0d want 0000000 0", outs, state_o);
        end
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 1, 1, (i == 4) ? 1'b1 : 1'b0, 0, 0);
            if (state_o === 2'd1) waits++;
            checks++;
            if (outs !== ((i == 4) ? 7'b1111100 : 7'b0000000)) begin
                errors++;
                $display("FAIL memwait_outs cycle %0d: got %b", i, outs);
            end
            tick();
        end
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (waits != 5 || state_o !== 2'd0 || stall_cycles !== CNT_W'(s0 + 5)) begin
            errors++;
            $display("FAIL memwait_end: waits %0d state %0d stall %0d want 5 0 %0d",
                     waits, state_o, stall_cycles, s0 + 5);
        end
        tick();
    endtask

    task automatic test_timeout_boundary();
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 1, 1, 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 1, 1, 1, 0, 0);
        checks++;
        if (state_o !== 2'd1 || outs !== 7'b1111100) begin
            errors++;
            $display("FAIL timeout_ack_wins_cycle: state %0d outs %b want 1 1111100", state_o, outs);
        end
        tick();
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (state_o !== 2'd0 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_ack_wins: state %0d err %b want 0 0", state_o, mem_err);
        end
        tick();
    endtask

    task automatic test_timeout();
        drive(1, 0, 0, 1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 17; i++) begin
            drive(0, 0, 0, 1, 1, 0, 0, 0);
            checks++;
            if (state_o !== ((i == 0) ? 2'd0 : 2'd1) || outs !== 7'b0000000 || mem_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait cycle %0d: state %0d outs %b err %b", i, state_o, outs, mem_err);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1, 0, 1, 0, 1);
            checks++;
            if (state_o !== 2'd3 || mem_err !== 1'b1 || outs !== 7'b0000000) begin
                errors++;
                $display("FAIL timeout_error cycle %0d: state %0d err %b outs %b want 3 1 0000000",
                         i, state_o, mem_err, outs);
            end
            tick();
        end
        drive(1, 0, 0, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (state_o !== 2'd0 || mem_err !== 1'b0 || stall_cycles !== '0) begin
            errors++;
            $display("FAIL timeout_reset: state %0d err %b stall %0d want 0 0 0", state_o, mem_err, stall_cycles);
        end
        tick();
    endtask

    task automatic test_halt();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0, 0, 1, 0);
            checks++;
            if (state_o !== ((i == 0) ? 2'd0 : 2'd2) || outs !== 7'b0000000) begin
                errors++;
                $display("FAIL halt cycle %0d: state %0d outs %b", i, state_o, outs);
            end
            tick();
        end
        drive(0, 0, 0, 1, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (state_o !== 2'd0 || outs !== 7'b1111100) begin
            errors++;
            $display("FAIL halt_resume: state %0d outs %b want 0 1111100", state_o, outs);
        end
        tick();
    endtask

    task automatic test_halt_during_wait();
        drive(0, 0, 0, 1, 1, 0, 1, 0);
        tick();
        drive(0, 0, 0, 1, 1, 0, 1, 0);
        tick();
        drive(0, 0, 0, 1, 1, 1, 1, 0);
        checks++;
        if (state_o !== 2'd1 || outs !== 7'b1111100) begin
            errors++;
            $display("FAIL halt_wait_ack: state %0d outs %b want 1 1111100", state_o, outs);
        end
        tick();
        drive(0, 0, 0, 1, 0, 0, 1, 0);
        checks++;
        if (state_o !== 2'd0 || outs !== 7'b0000000) begin
            errors++;
            $display("FAIL halt_wait_run: state %0d outs %b want 0 0000000", state_o, outs);
        end
        tick();
        drive(0, 0, 0, 1, 0, 0, 0, 1);
        checks++;
        if (state_o !== 2'd2) begin
            errors++;
            $display("FAIL halt_wait_halted: state %0d want 2", state_o);
        end
        tick();
    endtask

    task automatic test_saturation();
        drive(1, 0, 0, 1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 0, 1, 0, 0, 1, 0);
            tick();
        end
        drive(0, 0, 0, 1, 0, 0, 1, 0);
        checks++;
        if (s_stall_cycles !== 4'hF || stall_cycles !== CNT_W'(20)) begin
            errors++;
            $display("FAIL saturate: small %0d wide %0d want 15 20", s_stall_cycles, stall_cycles);
        end
        tick();
        drive(0, 0, 0, 1, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_random();
        logic [6:0] e;
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
            e = model_outs();
            checks++;
            if (outs !== e || s_outs !== e) begin
                errors++;
                $display("FAIL random_outs cycle %0d: got %b/%b want %b", i, outs, s_outs, e);
            end
            checks++;
            if (state_o !== 2'(m_mode) || s_state_o !== 2'(m_mode) || mem_err !== m_err || s_mem_err !== m_err) begin
                errors++;
                $display("FAIL random_state cycle %0d: state %0d/%0d err %b/%b want %0d %b",
                         i, state_o, s_state_o, mem_err, s_mem_err, m_mode, m_err);
            end
            checks++;
            if (stall_cycles !== CNT_W'(m_stall) || s_stall_cycles !== small_stall()) begin
                errors++;
                $display("FAIL random_stall cycle %0d: got %0d/%0d want %0d/%0d",
                         i, stall_cycles, s_stall_cycles, m_stall, small_stall());
            end
            tick();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; bubble = 1'b0; redirect_x = 1'b0; imem_ack = 1'b1;
        dmem_req_m = 1'b0; dmem_ack = 1'b0; halt = 1'b0; resume = 1'b0;
        test_reset();
        test_bubble();
        test_bubble_redirect();
        test_mem_wait();
        test_timeout_boundary();
        test_timeout();
        test_halt();
        test_halt_during_wait();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
